// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: steps a 3-bit select plus enable through the lines
// of a downstream 3-to-8 decoder, holding each line for a programmable dwell.
// Optional feature macro: SCAN_SKIP_MASK_EN (adds skip_mask[7:0]; masked
// lines are never driven).
//
// Handshake: start is a level request that is accepted on any edge where the
// sequencer is idle (busy=0) and stop=0; busy acts as "not ready", so start is
// ignored while busy=1. dir/one_shot/dwell (and skip_mask) are captured only
// on the accepting edge.
module decoder_scan_sequencer #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               dir,
   input  logic               one_shot,
   input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_SKIP_MASK_EN
   input  logic [7:0]         skip_mask,
`endif
   output logic               a0,
   output logic               a1,
   output logic               a2,
   output logic               dec_en,
   output logic               busy,
   output logic               done,
   output logic               wrap,
   output logic               state_dbg
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t             state, n_state;
   logic [2:0]         addr, n_addr;
   logic [DWELL_W-1:0] cnt, n_cnt;
   logic [DWELL_W-1:0] reload, n_reload;
   logic               dir_q, n_dir_q;
   logic               os_q, n_os_q;
   logic               done_q, n_done;
   logic               wrap_q, n_wrap;
   logic [7:0]         mask_q;
   logic [7:0]         start_mask;
   logic [2:0]         last_line;

`ifdef SCAN_SKIP_MASK_EN
   logic [7:0] n_mask;
   assign start_mask = skip_mask;
`else
   assign mask_q     = 8'h00;
   assign start_mask = 8'h00;
`endif

   // First unmasked line met when scanning from the start point in direction d.
   function automatic logic [2:0] first_line(input logic d, input logic [7:0] m);
      logic [2:0] r;
      logic [2:0] p;
      logic       found;
      r     = d ? 3'd7 : 3'd0;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         p = d ? 3'(7 - i) : 3'(i);
         if (!found && !m[p]) begin
            r     = p;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   // Next unmasked line after a, searching circularly in direction d.
   function automatic logic [2:0] step_line(input logic [2:0] a, input logic d,
                                            input logic [7:0] m);
      logic [2:0] r;
      logic [2:0] p;
      logic       found;
      r     = a;
      found = 1'b0;
      for (int i = 1; i < 8; i++) begin
         p = d ? a - 3'(i) : a + 3'(i);
         if (!found && !m[p]) begin
            r     = p;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   // The last line before the wrap point is the first line of the opposite scan.
   assign last_line = first_line(~dir_q, mask_q);

   // Next-state and next-output logic for the IDLE/RUN sequencer.
   always_comb begin
      n_state  = state;
      n_addr   = addr;
      n_cnt    = cnt;
      n_reload = reload;
      n_dir_q  = dir_q;
      n_os_q   = os_q;
      n_done   = 1'b0;
      n_wrap   = 1'b0;
`ifdef SCAN_SKIP_MASK_EN
      n_mask   = mask_q;
`endif
      case (state)
         IDLE: begin
            if (start && !stop) begin
               if (&start_mask) begin
                  n_done = 1'b1;
               end else begin
                  n_state  = RUN;
                  n_addr   = first_line(dir, start_mask);
                  n_dir_q  = dir;
                  n_os_q   = one_shot;
                  n_reload = (dwell == '0) ? '0 : dwell - 1'b1;
                  n_cnt    = (dwell == '0) ? '0 : dwell - 1'b1;
`ifdef SCAN_SKIP_MASK_EN
                  n_mask   = start_mask;
`endif
               end
            end
         end
         RUN: begin
            if (stop) begin
               n_state = IDLE;
            end else if (cnt != '0) begin
               n_cnt = cnt - 1'b1;
            end else if (addr != last_line) begin
               n_addr = step_line(addr, dir_q, mask_q);
               n_cnt  = reload;
            end else if (!os_q) begin
               n_addr = first_line(dir_q, mask_q);
               n_cnt  = reload;
               n_wrap = 1'b1;
            end else begin
               n_state = IDLE;
               n_done  = 1'b1;
            end
         end
         default: n_state = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         addr   <= 3'd0;
         cnt    <= '0;
         reload <= '0;
         dir_q  <= 1'b0;
         os_q   <= 1'b0;
         done_q <= 1'b0;
         wrap_q <= 1'b0;
`ifdef SCAN_SKIP_MASK_EN
         mask_q <= 8'h00;
`endif
      end else begin
         state  <= n_state;
         addr   <= n_addr;
         cnt    <= n_cnt;
         reload <= n_reload;
         dir_q  <= n_dir_q;
         os_q   <= n_os_q;
         done_q <= n_done;
         wrap_q <= n_wrap;
`ifdef SCAN_SKIP_MASK_EN
         mask_q <= n_mask;
`endif
      end
   end

   assign a0        = addr[0];
   assign a1        = addr[1];
   assign a2        = addr[2];
   assign dec_en    = (state == RUN);
   assign busy      = (state == RUN);
   assign done      = done_q;
   assign wrap      = wrap_q;
   assign state_dbg = (state == RUN);

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb_decoder_scan_sequencer: randomized and directed stimulus for the scan
// sequencer, checked every cycle against a list-based behavioural model.
// Honours SCAN_SKIP_MASK_EN when defined.
module tb_decoder_scan_sequencer;

   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rst, start, stop, dir, one_shot;
   logic [7:0] dwell;
   logic [7:0] skip_mask;
   logic       a0, a1, a2, dec_en, busy, done, wrap, state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] exp_q[$];

   decoder_scan_sequencer #(.DWELL_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .dir       (dir),
      .one_shot  (one_shot),
      .dwell     (dwell),
`ifdef SCAN_SKIP_MASK_EN
      .skip_mask (skip_mask),
`endif
      .a0        (a0),
      .a1        (a1),
      .a2        (a2),
      .dec_en    (dec_en),
      .busy      (busy),
      .done      (done),
      .wrap      (wrap),
      .state_dbg (state_dbg)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int cur_addr();
      return int'({a2, a1, a0});
   endfunction

   // ---------------- behavioural model ----------------
   // A scan is the ordered list of lines to visit; each entry is held for
   // max(dwell,1) cycles, then the next entry follows.
   logic m_run = 1'b0, m_done = 1'b0, m_wrap = 1'b0, m_os = 1'b0;
   int   m_addr = 0, m_idx = 0, m_age = 0, m_hold = 1;
   int   m_seq[$];

   always @(posedge clk) begin
      if (rst) begin
         m_run = 1'b0; m_addr = 0; m_done = 1'b0; m_wrap = 1'b0;
         m_seq.delete();
      end else begin
         m_done = 1'b0;
         m_wrap = 1'b0;
         if (!m_run) begin
            if (start && !stop) begin
               m_seq.delete();
               for (int i = 0; i < 8; i++) begin
                  int line;
                  line = dir ? 7 - i : i;
`ifdef SCAN_SKIP_MASK_EN
                  if (!skip_mask[line]) m_seq.push_back(line);
`else
                  m_seq.push_back(line);
`endif
               end
               if (m_seq.size() == 0) begin
                  m_done = 1'b1;
               end else begin
                  m_run  = 1'b1;
                  m_idx  = 0;
                  m_age  = 0;
                  m_hold = (dwell == 0) ? 1 : int'(dwell);
                  m_os   = one_shot;
                  m_addr = m_seq[0];
               end
            end
         end else if (stop) begin
            m_run = 1'b0;
         end else begin
            m_age++;
            if (m_age == m_hold) begin
               m_age = 0;
               m_idx++;
               if (m_idx == m_seq.size()) begin
                  if (m_os) begin
                     m_run  = 1'b0;
                     m_done = 1'b1;
                  end else begin
                     m_idx  = 0;
                     m_wrap = 1'b1;
                  end
               end
               if (m_run) m_addr = m_seq[m_idx];
            end
         end
      end
      exp_q.push_back({3'(m_addr), m_run, m_run, m_done, m_wrap, m_run});
   end

   // scoreboard: compare every cycle, away from the active edge
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("model", {a2, a1, a0, dec_en, busy, done, wrap, state_dbg}, e);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      start = 1'b0; stop = 1'b0;
   endtask

   task automatic cycle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic do_start(input logic d, input logic os, input logic [7:0] dw,
                           input logic [7:0] msk);
      dir = d; one_shot = os; dwell = dw; skip_mask = msk; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_addr(input int a, input int budget);
      int k;
      k = 0;
      while (!(busy === 1'b1 && cur_addr() == a) && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (k >= budget) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_addr: addr %0d not reached within %0d cycles", a, budget);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int bc, dc, wc, dn, a4;
      rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; one_shot = 1'b0;
      dwell = 8'd0; skip_mask = 8'h00;
      cycle(3);
      rst = 1'b0;
      check("reset_outputs", {a2, a1, a0, dec_en, busy, done, wrap}, 7'd0);

      // one-shot ascending, dwell 3
      do_start(1'b0, 1'b1, 8'd3, 8'h00);
      bc = 0; dc = -1; a4 = -1;
      for (int c = 1; c <= 40; c++) begin
         if (busy) bc++;
         if (done && dc < 0) dc = c;
         if (c == 4) a4 = cur_addr();
         @(negedge clk);
      end
      check("t1_busy_cycles", bc, 24);
      check("t1_done_cycle", dc, 25);
      check("t1_addr_cycle4", a4, 1);

      // continuous descending, dwell 0
      do_start(1'b1, 1'b0, 8'd0, 8'h00);
      wc = -1; dn = 0;
      for (int c = 1; c <= 20; c++) begin
         if (wrap && wc < 0) begin
            wc = c;
            check("t2_addr_at_wrap", cur_addr(), 7);
         end
         if (done) dn++;
         @(negedge clk);
      end
      check("t2_wrap_cycle", wc, 9);
      check("t2_no_done", dn, 0);
      stop = 1'b1; cycle(1); stop = 1'b0;

      // stop at addr 4, then restart
      do_start(1'b0, 1'b0, 8'd2, 8'h00);
      wait_addr(4, 40);
      stop = 1'b1; cycle(1); stop = 1'b0;
      check("t3_stop_outputs", {a2, a1, a0, dec_en, busy, done, wrap}, {3'd4, 4'b0000});
      cycle(2);
      do_start(1'b0, 1'b0, 8'd2, 8'h00);
      check("t3_restart_addr", {cur_addr() == 0, busy}, 2'b11);

      // reset mid-scan at addr 5; start+stop together stays idle
      wait_addr(5, 40);
      rst = 1'b1; cycle(1); rst = 1'b0;
      check("t4_reset_midscan", {a2, a1, a0, dec_en, busy, done, wrap, state_dbg}, 8'd0);
      start = 1'b1; stop = 1'b1; cycle(1); idle_inputs();
      check("t4_start_stop_idle", {busy, state_dbg}, 2'b00);

      // start pulsed while busy with dir toggled is ignored
      do_start(1'b0, 1'b1, 8'd1, 8'h00);
      cycle(2);
      dir = 1'b1; start = 1'b1; cycle(1); start = 1'b0;
      check("t5_addr_unchanged", cur_addr(), 3);
      dc = -1;
      for (int c = 4; c <= 20; c++) begin
         if (done && dc < 0) dc = c;
         @(negedge clk);
      end
      check("t5_done_cycle", dc, 9);

`ifdef SCAN_SKIP_MASK_EN
      begin
         int seen[$];
         do_start(1'b0, 1'b1, 8'd1, 8'b1010_0101);
         dn = 0;
         for (int c = 0; c < 12; c++) begin
            if (dec_en) seen.push_back(cur_addr());
            if (done) dn++;
            @(negedge clk);
         end
         check("t6_len", seen.size(), 4);
         if (seen.size() == 4) begin
            check("t6_l0", seen[0], 1);
            check("t6_l1", seen[1], 3);
            check("t6_l2", seen[2], 4);
            check("t6_l3", seen[3], 6);
         end
         check("t6_done_count", dn, 1);
         do_start(1'b0, 1'b1, 8'd1, 8'hFF);
         check("t6_ff_done", {done, dec_en, busy}, 3'b100);
         cycle(1);
         check("t6_ff_after", {done, dec_en, busy}, 3'b000);
      end
`endif

      // randomized phase, model-checked every cycle
      for (int c = 0; c < 3000; c++) begin
         rst      = ($urandom_range(0, 199) == 0);
         start    = ($urandom_range(0, 3) == 0);
         stop     = ($urandom_range(0, 24) == 0);
         dir      = 1'($urandom_range(0, 1));
         one_shot = 1'($urandom_range(0, 1));
         dwell    = 8'($urandom_range(0, 4));
         skip_mask = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
         @(negedge clk);
      end
      rst = 1'b0; idle_inputs();
      cycle(4);
      check("queue_drained", exp_q.size() <= 1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
Sequential address source placed directly upstream of the 3-to-8 decoder. Steps a 3-bit select (a0/a1/a2) and a decoder enable through the 8 decoder lines. Each line is held for a programmable dwell time. Supports up/down direction, continuous or single-pass operation, and start/stop control. Typical uses: LED/digit scanning and one-hot strobe generation.

Parameters:
DWELL_W, 8, width of the dwell-count input and the internal dwell counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  level-sampled request to begin a scan; ignored while busy
stop  input  1  abort a running scan
dir  input  1  0 = ascending 0→7, 1 = descending 7→0; sampled on accepted start
one_shot  input  1  1 = single pass then finish, 0 = continuous wrap; sampled on accepted start
dwell  input  DWELL_W  cycles each line is held; sampled on accepted start; 0 treated as 1
a0  output  1  select bit 0 to decoder
a1  output  1  select bit 1 to decoder
a2  output  1  select bit 2 to decoder
dec_en  output  1  decoder enable; high only while a line is being driven
busy  output  1  high while in RUN
done  output  1  one-cycle pulse at normal end of a one-shot pass
wrap  output  1  one-cycle pulse when a continuous scan wraps

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Reset: rst has priority over all inputs. On the next edge: state=IDLE, {a2,a1,a0}=0, dec_en=0, busy=0, done=0, wrap=0, dwell counter=0. Applies equally mid-scan.
- States: IDLE, RUN. All outputs are registered.
- IDLE:
  - start=1 and stop=0 → next edge: enter RUN, load addr with 0 (dir=0) or 7 (dir=1), latch dir/one_shot/dwell, set counter to max(dwell,1)-1, dec_en=1, busy=1.
  - start and stop both high → stop wins; remain IDLE.
- RUN, stop=1 → next edge: IDLE, dec_en=0, busy=0, addr held at its current value, no done/wrap pulse. stop beats any step event in the same cycle.
- RUN, counter>0 → counter decrements; addr unchanged.
- RUN, counter=0, addr not last (last = 7 ascending, 0 descending) → addr ±1, counter reloaded.
- RUN, counter=0, addr last, continuous → addr wraps to first (7→0 or 0→7), counter reloaded, wrap=1 for that one cycle, dec_en stays 1.
- RUN, counter=0, addr last, one_shot → IDLE, dec_en=0, busy=0, done=1 for one cycle, addr held at last.
- Dwell timing: each line is driven exactly max(dwell,1) consecutive cycles with dec_en=1. A one-shot pass lasts 8·max(dwell,1) cycles of busy.
- Input changes while busy: start is ignored. Changes to dir/one_shot/dwell take effect only on the next accepted start.
- Address arithmetic: 3-bit, modulo 8.
- done and wrap never assert in the same cycle. Neither asserts outside RUN→transition edges.

Optional Feature:
SCAN_SKIP_MASK_EN
- Defined:
  - Adds input skip_mask[7:0], sampled on accepted start. Lines with mask bit 1 are never driven.
  - First address = first unmasked line in the scan direction. Each step jumps to the next unmasked line (circular search, up to 7 positions).
  - "Last" = last unmasked line before the wrap point.
  - If only one line is unmasked: continuous mode pulses wrap every max(dwell,1) cycles.
  - If skip_mask=8'hFF at start: no RUN, dec_en stays 0, done pulses one cycle on the next edge.
- Undefined: port absent; all 8 lines visited.

Test Plan:
1. rst=1 then start=1, dir=0, one_shot=1, dwell=3 → addr 0..7 each held 3 cycles with dec_en=1; done pulses once at cycle 25 after start edge; busy high for 24 cycles.
2. dir=1, one_shot=0, dwell=0 → addr 7,6,…,0,7 on consecutive cycles (dwell treated as 1); wrap=1 exactly on the 0→7 cycle; done never asserts.
3. Continuous ascending run at dwell=2 → stop asserted while addr=4 → next edge dec_en=0, busy=0, addr=4, done=0; a later start restarts cleanly at addr 0.
4. rst asserted mid-scan at addr=5 → next edge all outputs 0, state IDLE; start and stop high together in IDLE → remains IDLE.
5. start pulsed while busy with dir toggled → ignored; scan continues unchanged until done.
6. (SCAN_SKIP_MASK_EN) skip_mask=8'b1010_0101, ascending, one_shot, dwell=1 → addr sequence 1,3,4,6 then done; skip_mask=8'hFF → done pulse next edge, dec_en never high.
